// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one picorv32-style memory slave.
// One idle cycle between transfers; an optional wait timeout forces completion with rdata 0.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        m0_mem_valid,
  output logic        m0_mem_ready,
  input  logic [31:0] m0_mem_addr,
  input  logic [31:0] m0_mem_wdata,
  input  logic [3:0]  m0_mem_wstrb,
  output logic [31:0] m0_mem_rdata,
  input  logic        m1_mem_valid,
  output logic        m1_mem_ready,
  input  logic [31:0] m1_mem_addr,
  input  logic [31:0] m1_mem_wdata,
  input  logic [3:0]  m1_mem_wstrb,
  output logic [31:0] m1_mem_rdata,
  output logic        s_mem_valid,
  input  logic        s_mem_ready,
  output logic [31:0] s_mem_addr,
  output logic [31:0] s_mem_wdata,
  output logic [3:0]  s_mem_wstrb,
  input  logic [31:0] s_mem_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT < 256) ? 8 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      grant_q, grant_d;
  logic            sel;
  logic            m_valid;
  logic            rdy;
  logic [31:0]     rdata;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    sel         = (state_q == GNT1);
    m_valid     = sel ? m1_mem_valid : m0_mem_valid;
    s_mem_valid = 1'b0;
    s_mem_addr  = '0;
    s_mem_wdata = '0;
    s_mem_wstrb = '0;
    rdy         = 1'b0;
    rdata       = '0;
    timeout_err = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_mem_valid && m1_mem_valid) state_d = last_q ? GNT0 : GNT1;
        else if (m0_mem_valid)            state_d = GNT0;
        else if (m1_mem_valid)            state_d = GNT1;
      end
      GNT0, GNT1: begin
        s_mem_valid = m_valid;
        s_mem_addr  = sel ? m1_mem_addr  : m0_mem_addr;
        s_mem_wdata = sel ? m1_mem_wdata : m0_mem_wdata;
        s_mem_wstrb = sel ? m1_mem_wstrb : m0_mem_wstrb;
        rdata       = s_mem_rdata;
        // A dropped valid is a protocol violation: abandon without a ready or a turn change.
        if (!m_valid) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_mem_ready) begin
          rdy     = 1'b1;
          state_d = IDLE;
          last_d  = sel;
          cnt_d   = '0;
        end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT_V)) begin
          rdy         = 1'b1;
          rdata       = '0;
          s_mem_valid = 1'b0;
          timeout_err = 1'b1;
          state_d     = IDLE;
          last_d      = sel;
          cnt_d       = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == GNT1, state_d == GNT0};
  end

  assign m0_mem_ready = rdy & (state_q == GNT0);
  assign m1_mem_ready = rdy & (state_q == GNT1);
  assign m0_mem_rdata = (state_q == GNT0) ? rdata : '0;
  assign m1_mem_rdata = (state_q == GNT1) ? rdata : '0;
  assign grant        = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked cycle by cycle against a
// transfer-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];
  logic        s_ready = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        m0_rdy, m1_rdy, s_valid, tmo;
  logic [31:0] m0_rd, m1_rd, s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;

  // model: own 0 = idle, 1 = m0, 2 = m1; waited = slave-wait cycles so far
  int own = 0, last = 1, waited = 0;
  logic [1:0] got_rdy = 2'b00;
  int rem [2];
  int raise_pct = 100;
  int lat = -1;
  bit slave_rand = 0;
  bit sready_force = 0;
  logic [31:0] fixed_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .nrst(nrst),
    .m0_mem_valid(mv[0]), .m0_mem_ready(m0_rdy), .m0_mem_addr(ma[0]),
    .m0_mem_wdata(mw[0]), .m0_mem_wstrb(ms[0]), .m0_mem_rdata(m0_rd),
    .m1_mem_valid(mv[1]), .m1_mem_ready(m1_rdy), .m1_mem_addr(ma[1]),
    .m1_mem_wdata(mw[1]), .m1_mem_wstrb(ms[1]), .m1_mem_rdata(m1_rd),
    .s_mem_valid(s_valid), .s_mem_ready(s_ready), .s_mem_addr(s_addr),
    .s_mem_wdata(s_wdata), .s_mem_wstrb(s_wstrb), .s_mem_rdata(s_rdata),
    .grant(grant), .timeout_err(tmo)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1;
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = 4'($urandom_range(15));
  endtask

  // Called at posedge+1: compares outputs at posedge+3, then advances the model at the next edge.
  task automatic cycle();
    logic [1:0]  eg;
    logic        esv, eto;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    logic [31:0] er [2];
    logic        erdy [2];
    int nown, nlast, nwait, x;
    #2;
    if (!nrst) begin own = 0; last = 1; waited = 0; end
    eg = 2'b00; esv = 1'b0; eto = 1'b0; ea = '0; ew = '0; es = '0;
    er[0] = '0; er[1] = '0; erdy[0] = 1'b0; erdy[1] = 1'b0;
    nown = own; nlast = last; nwait = waited;
    if (own == 0) begin
      if (mv[0] && mv[1]) nown = (last == 1) ? 1 : 2;
      else if (mv[0])     nown = 1;
      else if (mv[1])     nown = 2;
      nwait = 0;
    end else begin
      x = own - 1;
      eg = (x == 0) ? 2'b01 : 2'b10;
      esv = mv[x]; ea = ma[x]; ew = mw[x]; es = ms[x]; er[x] = s_rdata;
      if (!mv[x]) begin
        nown = 0;
      end else if (s_ready) begin
        erdy[x] = 1'b1; nown = 0; nlast = x;
        $display("xfer m%0d addr=%h wstrb=%h rdata=%h", x, ma[x], ms[x], s_rdata);
      end else if (TO != 0 && waited == TO) begin
        erdy[x] = 1'b1; er[x] = '0; esv = 1'b0; eto = 1'b1; nown = 0; nlast = x;
        $display("xfer m%0d addr=%h timeout", x, ma[x]);
      end else begin
        nwait = waited + 1;
      end
    end
    if (!nrst) begin nown = 0; nlast = 1; nwait = 0; end
    check_eq("grant",    32'(grant),   32'(eg));
    check_eq("s_valid",  32'(s_valid), 32'(esv));
    check_eq("s_addr",   s_addr,       ea);
    check_eq("s_wdata",  s_wdata,      ew);
    check_eq("s_wstrb",  32'(s_wstrb), 32'(es));
    check_eq("m0_ready", 32'(m0_rdy),  32'(erdy[0]));
    check_eq("m1_ready", 32'(m1_rdy),  32'(erdy[1]));
    check_eq("m0_rdata", m0_rd,        er[0]);
    check_eq("m1_rdata", m1_rd,        er[1]);
    check_eq("timeout",  32'(tmo),     32'(eto));
    got_rdy = {erdy[1], erdy[0]};
    @(posedge clk);
    own = nown; last = nlast; waited = nwait;
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (mv[i] && got_rdy[i]) begin rem[i]--; mv[i] = 1'b0; end
      if (!mv[i] && rem[i] > 0 && $urandom_range(99) < 32'(raise_pct)) new_req(i);
    end
    if (slave_rand) s_ready = ($urandom_range(3) == 0);
    else            s_ready = sready_force || (own != 0 && waited == lat);
    s_rdata = slave_rand ? $urandom : fixed_rdata;
  endtask

  task automatic run(input int n);
    repeat (n) begin drive(); cycle(); end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    mv[0] = 1'b0; mv[1] = 1'b0; rem[0] = 0; rem[1] = 0;
    got_rdy = 2'b00; sready_force = 0; slave_rand = 0; raise_pct = 100;
    run(2);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0; rem[i] = 0;
    end
    @(posedge clk); #1;
    run(2);
    nrst = 1'b1;

    // lone m0 read, slave answers on the third granted cycle
    lat = 2; fixed_rdata = 32'h1234_5678;
    rem[0] = 1; new_req(0); ma[0] = 32'h0000_0010; ms[0] = 4'h0;
    run(8);

    // both masters valid from reset, continuous requests
    do_reset();
    rem[0] = 4; rem[1] = 4; new_req(0); new_req(1);
    lat = 0; nrst = 1'b1;
    run(20);

    // m1 write with m0 arriving mid-transfer
    do_reset(); nrst = 1'b1; lat = 3;
    rem[1] = 1; mv[1] = 1'b1; ma[1] = 32'h2000_0004; mw[1] = 32'hCAFE_F00D; ms[1] = 4'b0011;
    run(2);
    rem[0] = 1; new_req(0);
    run(12);

    // slave never ready: forced completion, then a stray ready in IDLE
    do_reset(); nrst = 1'b1; lat = -1;
    rem[0] = 1; new_req(0);
    run(8);
    sready_force = 1; run(1); sready_force = 0; run(2);

    // slave ready exactly when the timeout would fire
    lat = TO; rem[0] = 1; new_req(0);
    run(9);

    // asynchronous reset during an m1 wait, then contention after release
    do_reset(); nrst = 1'b1; lat = -1;
    rem[1] = 1; new_req(1);
    run(3);
    nrst = 1'b0; cycle();
    run(2);
    mv[0] = 1'b0; mv[1] = 1'b0; rem[0] = 1; rem[1] = 1; new_req(0); new_req(1);
    lat = 1; nrst = 1'b1;
    run(10);

    // random traffic
    do_reset(); nrst = 1'b1;
    slave_rand = 1; raise_pct = 50; rem[0] = 1000; rem[1] = 1000;
    run(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255; slave-wait cycles before forced completion; 0 disables the timeout.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 m0_mem_valid, m1_mem_valid  input  1 each  master request, picorv32 native protocol.
REQ-005 m0_mem_ready, m1_mem_ready  output  1 each  master transfer complete.
REQ-006 m0_mem_addr, m1_mem_addr  input  32 each  master byte address.
REQ-007 m0_mem_wdata, m1_mem_wdata  input  32 each  master write data.
REQ-008 m0_mem_wstrb, m1_mem_wstrb  input  4 each  byte write strobes; 0 means read.
REQ-009 m0_mem_rdata, m1_mem_rdata  output  32 each  master read data.
REQ-010 s_mem_valid  output  1  shared slave request; feeds the address decoder.
REQ-011 s_mem_ready  input  1  shared slave completion.
REQ-012 s_mem_addr, s_mem_wdata  output  32 each  forwarded from the granted master.
REQ-013 s_mem_wstrb  output  4  forwarded from the granted master.
REQ-014 s_mem_rdata  input  32  slave read data.
REQ-015 grant  output  2  one-hot owner: bit0 = m0, bit1 = m1, 00 = idle.
REQ-016 timeout_err  output  1  one-cycle pulse on forced completion.

Function
REQ-017 FSM states: IDLE, GNT0, GNT1; state register plus last-served pointer `last` (0 = m0, 1 = m1).
REQ-018 IDLE, only mX_mem_valid high -> GNTX next cycle.
REQ-019 IDLE, both valid -> grant the master other than `last` (round-robin).
REQ-020 IDLE, no valid -> stay IDLE.
REQ-021 Arbitration latency is exactly one cycle; s_mem_valid is never high in IDLE.
REQ-022 In GNTX: s_mem_valid = mX_mem_valid.
REQ-023 In GNTX: s_mem_addr, s_mem_wdata and s_mem_wstrb are combinationally muxed from master X.
REQ-024 In GNTX: mX_mem_ready = s_mem_ready, and mX_mem_rdata = s_mem_rdata.
REQ-025 The non-granted master sees ready = 0 and rdata = 0.
REQ-026 In IDLE: all s_mem_* outputs are 0.
REQ-027 GNTX with s_mem_ready high -> IDLE next cycle, and `last` <= X.
REQ-028 GNTX with mX_mem_valid low (protocol violation) -> IDLE next cycle; `last` unchanged; no ready issued.
REQ-029 Wait counter: 8+ bits, wide enough for TIMEOUT. Cleared in IDLE; increments each GNTX cycle with s_mem_ready low.
REQ-030 TIMEOUT != 0 and counter == TIMEOUT, with s_mem_ready low, triggers forced completion in the same cycle:
  - mX_mem_ready = 1
  - mX_mem_rdata = 32'h0
  - s_mem_valid = 0
  - timeout_err = 1
  - IDLE next cycle; `last` <= X
REQ-031 s_mem_ready and the timeout in the same cycle: s_mem_ready wins; normal completion; timeout_err stays 0.
REQ-032 s_mem_ready high while in IDLE is ignored.
REQ-033 A master is not re-granted in the cycle its ready is issued.
  - Minimum per-transfer overhead: 1 idle cycle.
  - Back-to-back requests from both masters alternate strictly.
REQ-034 grant is a registered decode of the state; it is glitch-free.

Reset
REQ-035 nrst low asynchronously forces:
  - state = IDLE, `last` = 1 (m0 wins the first contention), counter = 0
  - all outputs 0: grant = 00, timeout_err = 0, s_mem_valid = 0, both mX_mem_ready = 0
REQ-036 Reset mid-transfer abandons the transfer; no ready is issued.
REQ-037 After nrst rises, the first arbitration occurs on the first posedge with any valid high.

Verification
REQ-038 m0 read at 0x0000_0010 alone, slave ready after 3 cycles with rdata 0x1234_5678:
  - grant 01 one cycle after valid
  - m0_mem_ready pulses once with rdata 0x1234_5678
  - m1 sees ready 0
REQ-039 Both masters valid from reset, continuous requests:
  - grants in order m0, m1, m0, m1
  - each with a single IDLE cycle between
REQ-040 m1 write 0x2000_0004, wstrb 4'b0011, wdata 0xCAFE_F00D:
  - s_mem_* carries exactly those values while grant = 10
  - m0 request raised mid-transfer is served only after completion
REQ-041 TIMEOUT = 4, slave never ready:
  - m0_mem_ready and timeout_err pulse together on the 5th GNT0 cycle
  - rdata 0; state returns to IDLE
  - a later s_mem_ready pulse is ignored
REQ-042 TIMEOUT = 4, s_mem_ready on the same cycle the counter reaches 4: normal completion, timeout_err 0.
REQ-043 nrst asserted during GNT1 wait:
  - outputs go 0 immediately, without waiting for a clock edge
  - after release, simultaneous requests grant m0 first
